// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with PC, single-outstanding memory request
// handshake, a small prefetch FIFO and taken-branch redirect/flush.
// Optional feature macro: FETCH_BYPASS_EN (same-cycle pass-through of a
// returning word when the FIFO is empty).
module fetch_stage #(
   parameter int             N        = 32,
   parameter logic [N-1:0]   RESET_PC = '0,
   parameter int             DEPTH    = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           stall_D,
   input  logic           redirect_E,
   input  logic [N-1:0]   target_E,
   output logic           imem_req,
   output logic [N-1:0]   imem_addr,
   input  logic           imem_ready,
   input  logic [N-1:0]   imem_rdata,
   output logic [N-1:0]   inst_F,
   output logic [N-1:0]   pc_F,
   output logic           valid_F,
   output logic           flush_F
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_FULL = 2'd1,
      S_RDR  = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [N-1:0]    pc;
   logic [CW-1:0]   count, count_nxt;
   logic [PW-1:0]   rd_ptr, wr_ptr;
   logic [N-1:0]    fifo_inst [DEPTH];
   logic [N-1:0]    fifo_pc   [DEPTH];

   logic            fifo_empty;
   logic            push;
   logic            wr_en;
   logic            rd_en;
   logic            head_vld;
   logic [N-1:0]    head_inst;
   logic [N-1:0]    head_pc;

   // Circular pointer advance that also works for non power-of-two depths.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Branch targets are word aligned; the low two bits are dropped.
   function automatic logic [N-1:0] align_pc(input logic [N-1:0] a);
      return {a[N-1:2], 2'b00};
   endfunction

   assign fifo_empty = (count == '0);
   assign imem_addr  = pc;

   // A returning word is accepted only while requesting and not redirecting.
   assign push = (state == S_REQ) && imem_ready && !redirect_E;

`ifdef FETCH_BYPASS_EN
   // Empty FIFO: the returning word is presented directly; it is stored only
   // when decode cannot take it this cycle.
   logic bypass;
   assign bypass    = fifo_empty && push;
   assign head_vld  = !fifo_empty || bypass;
   assign head_inst = fifo_empty ? imem_rdata : fifo_inst[rd_ptr];
   assign head_pc   = fifo_empty ? pc         : fifo_pc[rd_ptr];
   assign wr_en     = push && !(bypass && !stall_D);
`else
   // Every word passes through storage so the head is always registered.
   assign head_vld  = !fifo_empty;
   assign head_inst = fifo_inst[rd_ptr];
   assign head_pc   = fifo_pc[rd_ptr];
   assign wr_en     = push;
`endif

   assign rd_en   = !fifo_empty && !stall_D;
   assign valid_F = head_vld;
   assign inst_F  = head_vld ? head_inst : '0;
   assign pc_F    = head_vld ? head_pc   : '0;

   // Occupancy after this cycle's write/read.
   always_comb begin
      count_nxt = count;
      case ({wr_en, rd_en})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
   end

   // Next-state and request/flush outputs; redirect overrides any state.
   always_comb begin
      state_nxt = state;
      imem_req  = 1'b0;
      flush_F   = 1'b0;
      case (state)
         S_REQ: begin
            imem_req = rst;
            if (count_nxt == CW'(DEPTH))
               state_nxt = S_FULL;
         end
         S_FULL: begin
            if (rd_en)
               state_nxt = S_REQ;
         end
         S_RDR: begin
            flush_F   = 1'b1;
            state_nxt = S_REQ;
         end
         default: state_nxt = S_REQ;
      endcase
      if (redirect_E)
         state_nxt = S_RDR;
   end

   // Control state: FSM, PC and FIFO bookkeeping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= S_REQ;
         pc     <= RESET_PC;
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         state <= state_nxt;
         if (redirect_E) begin
            pc     <= align_pc(target_E);
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (push)
               pc <= pc + N'(4);
            count <= count_nxt;
            if (wr_en)
               wr_ptr <= ptr_inc(wr_ptr);
            if (rd_en)
               rd_ptr <= ptr_inc(rd_ptr);
         end
      end
   end

   // FIFO payload storage; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         fifo_inst[wr_ptr] <= imem_rdata;
         fifo_pc[wr_ptr]   <= pc;
      end
   end

endmodule
